// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, default frame geometry, even-parity helper.
// Pure declarations; no latency or flow-control behaviour of its own.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int MAX_DATA_BITS    = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Narrower words are zero-extended by the caller; zeros do not change the parity.
  function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser with a configurable reset level, for asynchronous single-bit inputs.
// Latency 2 clk; no backpressure.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (UART_RX_PARITY_EN adds an even-parity bit). rx_valid rises CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT+3 clk after rx falls.
// Output is held until rx_ack; a word completing while rx_valid is still unacknowledged overwrites it and pulses overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);

  rx_state_t state, state_nxt;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sr;
  logic                 mid_hit, end_hit;
  logic                 sample_bit, stop_smp, word_ok, par_ok;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (rx),
    .q   (rxs)
  );

  assign mid_hit = (cnt == CNT_MID);
  assign end_hit = (cnt == CNT_END);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rxs) state_nxt = START;
      START:  if (mid_hit) state_nxt = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (end_hit && bit_cnt == BIT_END) state_nxt = PARITY;
      PARITY: if (end_hit) state_nxt = STOP;
`else
      DATA:   if (end_hit && bit_cnt == BIT_END) state_nxt = STOP;
`endif
      STOP:   if (end_hit) state_nxt = rxs ? IDLE : BREAK;
      BREAK:  if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    sample_bit = (state == DATA) && end_hit;
    stop_smp   = (state == STOP) && end_hit;
    word_ok    = stop_smp && rxs && par_ok;
  end

`ifdef UART_RX_PARITY_EN
  logic                     par_bit;
  logic [MAX_DATA_BITS-1:0] sr_ext;

  always_comb begin
    sr_ext                = '0;
    sr_ext[DATA_BITS-1:0] = sr;
    par_ok                = (even_parity(sr_ext) == par_bit);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && end_hit) par_bit <= rxs;
      parity_err <= stop_smp && rxs && !par_ok;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  // Counters restart on every state change so each state times from its own entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      if (state == IDLE || state_nxt != state || end_hit) cnt <= '0;
      else                                                 cnt <= cnt + CW'(1);
      if (state_nxt != state) bit_cnt <= '0;
      else if (sample_bit)    bit_cnt <= bit_cnt + BW'(1);
      if (sample_bit) sr <= {rxs, sr[DATA_BITS-1:1]};
    end
  end

  // A load in the same cycle as an ack counts as consumed, not overrun.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_smp && !rxs;
      overrun   <= word_ok && rx_valid && !rx_ack;
      if (word_ok) begin
        rx_data  <= sr;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, expected words queued at send time.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 155 + CPB;
`else
  localparam int LAT = 155;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ack = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  int            pe_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .clr       (clr),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Pop the next expected word, compare with the DUT, then acknowledge it.
  task automatic recv_check(input string tag);
    logic [7:0] exp;
    bit got;
    got = 0;
    for (int i = 0; i < 4 * CPB; i++) begin
      if (rx_valid === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_valid"}, {31'd0, got}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    end
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    chk({tag, "_clr"}, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    int lat, fe0, ov0;
    logic [7:0] w;

    // Reset values
    idle(3);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    clr = 1'b1;
    idle(4);

    // First frame: latency, hold without ack, then single-cycle ack
    exp_q.push_back(8'hA5);
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk);
          if (rx_valid === 1'b1) begin
            lat = i;
            break;
          end
        end
      end
    join
    chk("a5_latency", lat, LAT);
    idle(20);
    chk("a5_hold_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_idle_busy", {31'd0, busy}, 32'd0);
    recv_check("a5");

    // Short glitch is rejected as a false start
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(4);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    idle(1);
    rx = 1'b1;
    idle(20);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr", fe_cnt - fe0, 0);

    // Stop bit low: one frame_err, nothing delivered, then recovery
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("ferr_count", fe_cnt - fe0, 1);
    chk("ferr_valid", {31'd0, rx_valid}, 32'd0);
    chk("ferr_break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(4);
    chk("ferr_released", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    recv_check("after_ferr");

    // Back-to-back without ack: second word overwrites and overrun pulses once
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_count", ov_cnt - ov0, 1);
    void'(exp_q.pop_front());
    recv_check("ovr");

    // Back-to-back with ack in the load cycle: no overrun, new word wins
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(negedge clk);
        chk("ackload_first", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk("ackload_valid", {31'd0, rx_valid}, 32'd1);
      end
    join
    chk("ackload_ovr", ov_cnt - ov0, 0);
    recv_check("ackload");

    // Line held low for 40 bit times: exactly one frame_err
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(40 * CPB);
    chk("hold_ferr", fe_cnt - fe0, 1);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_valid", {31'd0, rx_valid}, 32'd0);
    rx = 1'b1;
    idle(4);
    chk("hold_release", {31'd0, busy}, 32'd0);

    // Loopback of random words
    for (int k = 0; k < 50; k++) begin
      w = 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_frame(w, 1'b1, 1'b0);
      recv_check("loop");
    end

`ifdef UART_RX_PARITY_EN
    begin
      int pe0;
      pe0 = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(2);
      chk("par_err", pe_cnt - pe0, 1);
      chk("par_valid", {31'd0, rx_valid}, 32'd0);
    end
`endif

    // Reset in the middle of DATA with a word still pending
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
    chk("pre_rst_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(CPB / 2);
    clr = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    idle(3);
    clr = 1'b1;
    idle(4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    recv_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
